// File: rtl/ps2_key_event_tracker_pkg.sv
// Shared PS/2 key map: key indices, protocol byte constants, parser states and scan-code lookup.
// Latency: none (types, constants and combinational helper functions only).
// Backpressure: not applicable.
package ps2_key_event_tracker_pkg;

  // Number of keys in the shared map; key_state bit i belongs to key index i.
  localparam int NUMBEROFKEYBOARDINPUTS = 30;
  localparam int KEY_MAP_W = 5;

  // PS/2 scan-code set 2 prefix bytes.
  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;

  // Number row.
  localparam logic [KEY_MAP_W-1:0] KEY_1 = 5'd0;
  localparam logic [KEY_MAP_W-1:0] KEY_2 = 5'd1;
  localparam logic [KEY_MAP_W-1:0] KEY_3 = 5'd2;
  localparam logic [KEY_MAP_W-1:0] KEY_4 = 5'd3;
  localparam logic [KEY_MAP_W-1:0] KEY_5 = 5'd4;
  localparam logic [KEY_MAP_W-1:0] KEY_6 = 5'd5;
  localparam logic [KEY_MAP_W-1:0] KEY_7 = 5'd6;
  localparam logic [KEY_MAP_W-1:0] KEY_8 = 5'd7;
  localparam logic [KEY_MAP_W-1:0] KEY_9 = 5'd8;
  localparam logic [KEY_MAP_W-1:0] KEY_0 = 5'd9;
  // Top letter row.
  localparam logic [KEY_MAP_W-1:0] KEY_Q = 5'd10;
  localparam logic [KEY_MAP_W-1:0] KEY_W = 5'd11;
  localparam logic [KEY_MAP_W-1:0] KEY_E = 5'd12;
  localparam logic [KEY_MAP_W-1:0] KEY_R = 5'd13;
  localparam logic [KEY_MAP_W-1:0] KEY_T = 5'd14;
  localparam logic [KEY_MAP_W-1:0] KEY_Y = 5'd15;
  localparam logic [KEY_MAP_W-1:0] KEY_U = 5'd16;
  localparam logic [KEY_MAP_W-1:0] KEY_I = 5'd17;
  localparam logic [KEY_MAP_W-1:0] KEY_O = 5'd18;
  localparam logic [KEY_MAP_W-1:0] KEY_P = 5'd19;
  // Home row.
  localparam logic [KEY_MAP_W-1:0] KEY_A = 5'd20;
  localparam logic [KEY_MAP_W-1:0] KEY_S = 5'd21;
  localparam logic [KEY_MAP_W-1:0] KEY_D = 5'd22;
  localparam logic [KEY_MAP_W-1:0] KEY_F = 5'd23;
  localparam logic [KEY_MAP_W-1:0] KEY_G = 5'd24;
  localparam logic [KEY_MAP_W-1:0] KEY_H = 5'd25;
  localparam logic [KEY_MAP_W-1:0] KEY_J = 5'd26;
  localparam logic [KEY_MAP_W-1:0] KEY_K = 5'd27;
  localparam logic [KEY_MAP_W-1:0] KEY_L = 5'd28;
  localparam logic [KEY_MAP_W-1:0] KEY_SPACEBAR = 5'd29;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } parse_state_e;

  typedef struct packed {
    logic                 hit;
    logic [KEY_MAP_W-1:0] idx;
  } lookup_t;

  // Keyboard housekeeping bytes (BAT ok, ack, resend, error/overrun) that never name a key.
  function automatic logic is_ctrl_code(input logic [7:0] code);
    return (code == 8'hAA) || (code == 8'hFA) || (code == 8'hFE) ||
           (code == 8'h00) || (code == 8'hFF);
  endfunction

  // Maps a scan code to a key index; the extended (E0) table currently maps nothing.
  function automatic lookup_t key_lookup(input logic ext, input logic [7:0] code);
    lookup_t r;
    r.hit = 1'b1;
    r.idx = '0;
    if (ext) begin
      r.hit = 1'b0;
    end else begin
      case (code)
        8'h16: r.idx = KEY_1;
        8'h1E: r.idx = KEY_2;
        8'h26: r.idx = KEY_3;
        8'h25: r.idx = KEY_4;
        8'h2E: r.idx = KEY_5;
        8'h36: r.idx = KEY_6;
        8'h3D: r.idx = KEY_7;
        8'h3E: r.idx = KEY_8;
        8'h46: r.idx = KEY_9;
        8'h45: r.idx = KEY_0;
        8'h15: r.idx = KEY_Q;
        8'h1D: r.idx = KEY_W;
        8'h24: r.idx = KEY_E;
        8'h2D: r.idx = KEY_R;
        8'h2C: r.idx = KEY_T;
        8'h35: r.idx = KEY_Y;
        8'h3C: r.idx = KEY_U;
        8'h43: r.idx = KEY_I;
        8'h44: r.idx = KEY_O;
        8'h4D: r.idx = KEY_P;
        8'h1C: r.idx = KEY_A;
        8'h1B: r.idx = KEY_S;
        8'h23: r.idx = KEY_D;
        8'h2B: r.idx = KEY_F;
        8'h34: r.idx = KEY_G;
        8'h33: r.idx = KEY_H;
        8'h3B: r.idx = KEY_J;
        8'h42: r.idx = KEY_K;
        8'h4B: r.idx = KEY_L;
        8'h29: r.idx = KEY_SPACEBAR;
        default: r.hit = 1'b0;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/ps2_key_event_tracker_if.sv
// Byte input from the PS/2 receiver and key-event output stream of the tracker.
// Latency: none (wiring only).
// Backpressure: rx side is a strobe with no ready; event side pops on evt_valid & evt_ready.
interface ps2_key_event_tracker_if #(
  parameter int KEY_IDX_W = 5
);
  logic [7:0]           rx_data;
  logic                 rx_valid;
  logic                 evt_valid;
  logic [KEY_IDX_W-1:0] evt_key;
  logic                 evt_press;
  logic                 evt_ready;

  // Environment side: supplies bytes, consumes events.
  modport master (
    output rx_data, rx_valid, evt_ready,
    input  evt_valid, evt_key, evt_press
  );

  // Tracker side: consumes bytes, supplies events.
  modport slave (
    input  rx_data, rx_valid, evt_ready,
    output evt_valid, evt_key, evt_press
  );
endinterface

// File: rtl/ps2_event_fifo.sv
// Generic first-word-fall-through FIFO; head data is presented whenever the FIFO is non-empty.
// Latency: push visible at the head one cycle later when empty.
// Backpressure: push while full is refused unless a pop happens in the same cycle; pop while empty is ignored.
module ps2_event_fifo #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic             full,
  output logic             head_vld,
  output logic [WIDTH-1:0] head_dat
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             empty;
  logic             push_ok;
  logic             pop_ok;

  // Occupancy, handshake qualification and next pointer/storage state.
  always_comb begin
    empty    = (cnt_q == '0);
    full     = (cnt_q == CNT_W'(DEPTH));
    pop_ok   = pop && !empty;
    push_ok  = push && (!full || pop_ok);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    cnt_d = cnt_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
  end

  assign head_vld = !empty;
  assign head_dat = empty ? '0 : mem_q[rd_ptr_q];

  // Storage, pointers and count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end
endmodule

// File: rtl/ps2_key_event_tracker.sv
// Parses PS/2 make/break/extended byte sequences into a held-key vector and a press/release event queue.
// Latency: final byte strobed at cycle N -> key_state, release_pulse and (if queue empty) evt_valid at N+1.
// Backpressure: none on rx; events wait for evt_ready, and events arriving at a full queue are dropped (sticky evt_overflow).
module ps2_key_event_tracker
  import ps2_key_event_tracker_pkg::*;
#(
  parameter int NUM_KEYS   = NUMBEROFKEYBOARDINPUTS,
  parameter int FIFO_DEPTH = 8,
  parameter int EXT_ENABLE = 1,
  parameter int KEY_IDX_W  = $clog2(NUM_KEYS)
) (
  input  logic                      CLOCK_50,
  input  logic                      resetn,
  input  logic                      clear_state,
  ps2_key_event_tracker_if.slave    ps2,
  output logic [NUM_KEYS-1:0]       key_state,
  output logic                      release_pulse,
  output logic                      evt_overflow
);
  localparam int EVT_W = KEY_IDX_W + 1;

  parse_state_e          state_q, state_d;
  logic [NUM_KEYS-1:0]   key_state_q, key_state_d;
  logic                  release_pulse_q, release_pulse_d;
  logic                  evt_overflow_q, evt_overflow_d;

  lookup_t               lk;
  logic                  lk_hit;
  logic [KEY_IDX_W-1:0]  lk_idx;
  logic                  do_make;
  logic                  do_break;
  logic                  push;
  logic                  push_press;
  logic                  pop;
  logic                  fifo_full;
  logic [EVT_W-1:0]      head_dat;

  // Key lookup for the incoming byte; the table is chosen by whether an E0 prefix is pending.
  always_comb begin
    lk     = key_lookup((state_q == ST_EXT) || (state_q == ST_EXT_BRK), ps2.rx_data);
    lk_hit = lk.hit && (int'(lk.idx) < NUM_KEYS);
    lk_idx = KEY_IDX_W'(lk.idx);
  end

  // Parser next state, key_state update and event generation; clear_state overrides any byte.
  always_comb begin
    state_d         = state_q;
    key_state_d     = key_state_q;
    release_pulse_d = 1'b0;
    do_make         = 1'b0;
    do_break        = 1'b0;
    push            = 1'b0;
    push_press      = 1'b0;
    if (clear_state) begin
      state_d     = ST_IDLE;
      key_state_d = '0;
    end else if (ps2.rx_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (ps2.rx_data == PS2_BREAK) begin
            state_d = ST_BRK;
          end else if (ps2.rx_data == PS2_EXT) begin
            state_d = (EXT_ENABLE != 0) ? ST_EXT : ST_IDLE;
          end else if (!is_ctrl_code(ps2.rx_data)) begin
            do_make = 1'b1;
          end
        end
        ST_EXT: begin
          if (ps2.rx_data == PS2_BREAK) begin
            state_d = ST_EXT_BRK;
          end else begin
            state_d = ST_IDLE;
            do_make = !is_ctrl_code(ps2.rx_data) && (ps2.rx_data != PS2_EXT);
          end
        end
        ST_BRK, ST_EXT_BRK: begin
          state_d  = ST_IDLE;
          do_break = !is_ctrl_code(ps2.rx_data) && (ps2.rx_data != PS2_EXT) &&
                     (ps2.rx_data != PS2_BREAK);
        end
        default: state_d = ST_IDLE;
      endcase
      // Typematic repeats and releases of keys not held produce nothing.
      if (do_make && lk_hit && !key_state_q[lk_idx]) begin
        key_state_d[lk_idx] = 1'b1;
        push                = 1'b1;
        push_press          = 1'b1;
      end
      if (do_break && lk_hit && key_state_q[lk_idx]) begin
        key_state_d[lk_idx] = 1'b0;
        push                = 1'b1;
        release_pulse_d     = 1'b1;
      end
    end
  end

  assign pop = ps2.evt_valid && ps2.evt_ready;

  // Overflow is sticky until reset; a same-cycle pop frees the slot so nothing is lost.
  always_comb begin
    evt_overflow_d = evt_overflow_q | (push && fifo_full && !pop);
  end

  // Parser, key vector and status registers.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q         <= ST_IDLE;
      key_state_q     <= '0;
      release_pulse_q <= 1'b0;
      evt_overflow_q  <= 1'b0;
    end else begin
      state_q         <= state_d;
      key_state_q     <= key_state_d;
      release_pulse_q <= release_pulse_d;
      evt_overflow_q  <= evt_overflow_d;
    end
  end

  ps2_event_fifo #(
    .WIDTH (EVT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (CLOCK_50),
    .rst_n    (resetn),
    .push     (push),
    .push_dat ({lk_idx, push_press}),
    .pop      (pop),
    .full     (fifo_full),
    .head_vld (ps2.evt_valid),
    .head_dat (head_dat)
  );

  assign ps2.evt_key    = head_dat[EVT_W-1:1];
  assign ps2.evt_press  = head_dat[0];
  assign key_state      = key_state_q;
  assign release_pulse  = release_pulse_q;
  assign evt_overflow   = evt_overflow_q;
endmodule

// File: tb/tb_ps2_key_event_tracker.sv
// Directed bench for the PS/2 key event tracker (extended decoding on and off).
// Inputs change 1 time unit after the rising edge; outputs are sampled at that same point.
// Two instances share all stimulus so E0 handling can be compared directly.
module tb_ps2_key_event_tracker;
  localparam int NK = 30;
  localparam int KW = 5;

  logic          clk;
  logic          resetn;
  logic          clear_state;
  logic [NK-1:0] ks_a, ks_b;
  logic          rel_a, rel_b;
  logic          ovf_a, ovf_b;

  int checks = 0;
  int errors = 0;

  ps2_key_event_tracker_if #(.KEY_IDX_W(KW)) bus_a ();
  ps2_key_event_tracker_if #(.KEY_IDX_W(KW)) bus_b ();

  ps2_key_event_tracker #(.NUM_KEYS(NK), .FIFO_DEPTH(8), .EXT_ENABLE(1)) dut (
    .CLOCK_50      (clk),
    .resetn        (resetn),
    .clear_state   (clear_state),
    .ps2           (bus_a),
    .key_state     (ks_a),
    .release_pulse (rel_a),
    .evt_overflow  (ovf_a)
  );

  ps2_key_event_tracker #(.NUM_KEYS(NK), .FIFO_DEPTH(8), .EXT_ENABLE(0)) dut_ne (
    .CLOCK_50      (clk),
    .resetn        (resetn),
    .clear_state   (clear_state),
    .ps2           (bus_b),
    .key_state     (ks_b),
    .release_pulse (rel_b),
    .evt_overflow  (ovf_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    bus_a.rx_data  = b;
    bus_b.rx_data  = b;
    bus_a.rx_valid = 1'b1;
    bus_b.rx_valid = 1'b1;
    tick();
    bus_a.rx_valid = 1'b0;
    bus_b.rx_valid = 1'b0;
  endtask

  task automatic set_ready(input logic r);
    bus_a.evt_ready = r;
    bus_b.evt_ready = r;
  endtask

  task automatic pop();
    set_ready(1'b1);
    tick();
    set_ready(1'b0);
  endtask

  initial begin
    logic [7:0] num_row [10];
    int         drain3  [8];
    int         drain6  [4];
    num_row = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46, 8'h45};
    drain3  = '{1, 2, 3, 4, 5, 6, 7, 10};
    drain6  = '{1, 2, 0, 0};

    resetn      = 1'b0;
    clear_state = 1'b0;
    bus_a.rx_data = 8'h00; bus_a.rx_valid = 1'b0; bus_a.evt_ready = 1'b0;
    bus_b.rx_data = 8'h00; bus_b.rx_valid = 1'b0; bus_b.evt_ready = 1'b0;
    tick(); tick();

    // Reset state.
    chk("rst_key_state", 32'(ks_a), 32'h0);
    chk("rst_release", 32'(rel_a), 32'h0);
    chk("rst_evt_valid", 32'(bus_a.evt_valid), 32'h0);
    chk("rst_evt_key", 32'(bus_a.evt_key), 32'h0);
    chk("rst_evt_press", 32'(bus_a.evt_press), 32'h0);
    chk("rst_overflow", 32'(ovf_a), 32'h0);
    resetn = 1'b1;
    tick();

    // 1: Q press then release.
    send(8'h15);
    chk("t1_ks_q", 32'(ks_a), 32'h400);
    chk("t1_evt_valid", 32'(bus_a.evt_valid), 32'h1);
    chk("t1_evt_key", 32'(bus_a.evt_key), 32'd10);
    chk("t1_evt_press", 32'(bus_a.evt_press), 32'h1);
    chk("t1_rel_low", 32'(rel_a), 32'h0);
    pop();
    chk("t1_empty", 32'(bus_a.evt_valid), 32'h0);
    send(8'hF0);
    chk("t1_ks_after_f0", 32'(ks_a), 32'h400);
    send(8'h15);
    chk("t1_ks_clear", 32'(ks_a), 32'h0);
    chk("t1_rel_pulse", 32'(rel_a), 32'h1);
    chk("t1_rel_evt_key", 32'(bus_a.evt_key), 32'd10);
    chk("t1_rel_evt_press", 32'(bus_a.evt_press), 32'h0);
    tick();
    chk("t1_rel_one_cycle", 32'(rel_a), 32'h0);
    pop();
    chk("t1_empty2", 32'(bus_a.evt_valid), 32'h0);

    // 2: typematic repeat and release of a key that is not held.
    for (int i = 0; i < 5; i++) send(8'h15);
    chk("t2_ks_q", 32'(ks_a), 32'h400);
    chk("t2_evt_key", 32'(bus_a.evt_key), 32'd10);
    chk("t2_evt_press", 32'(bus_a.evt_press), 32'h1);
    pop();
    chk("t2_single_evt", 32'(bus_a.evt_valid), 32'h0);
    send(8'hF0);
    send(8'h1D);
    chk("t2_w_ks", 32'(ks_a), 32'h400);
    chk("t2_w_no_pulse", 32'(rel_a), 32'h0);
    chk("t2_w_no_evt", 32'(bus_a.evt_valid), 32'h0);
    send(8'hF0);
    send(8'h15);
    chk("t2_q_rel_pulse", 32'(rel_a), 32'h1);
    pop();

    // 3: overflow with evt_ready held low.
    for (int i = 0; i < 8; i++) send(num_row[i]);
    chk("t3_ovf_at_8", 32'(ovf_a), 32'h0);
    chk("t3_head_at_8", 32'(bus_a.evt_key), 32'd0);
    send(num_row[8]);
    chk("t3_ovf_at_9", 32'(ovf_a), 32'h1);
    chk("t3_ks_9", 32'(ks_a), 32'h1FF);
    send(num_row[9]);
    chk("t3_ks_10", 32'(ks_a), 32'h3FF);
    set_ready(1'b1);
    send(8'h15);
    set_ready(1'b0);
    chk("t3_ks_pushpop", 32'(ks_a), 32'h7FF);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t3_drain_vld%0d", i), 32'(bus_a.evt_valid), 32'h1);
      chk($sformatf("t3_drain_key%0d", i), 32'(bus_a.evt_key), 32'(drain3[i]));
      chk($sformatf("t3_drain_press%0d", i), 32'(bus_a.evt_press), 32'h1);
      pop();
    end
    chk("t3_drained", 32'(bus_a.evt_valid), 32'h0);
    clear_state = 1'b1;
    tick();
    clear_state = 1'b0;
    chk("t3_clear_ks", 32'(ks_a), 32'h0);
    chk("t3_ovf_kept", 32'(ovf_a), 32'h1);

    // 4: extended sequences with no extended mapping.
    send(8'hE0); send(8'hF0); send(8'h15);
    chk("t4_e0f015_ks", 32'(ks_a), 32'h0);
    chk("t4_e0f015_evt", 32'(bus_a.evt_valid), 32'h0);
    send(8'hE0); send(8'h29);
    chk("t4_e029_ks", 32'(ks_a), 32'h0);
    chk("t4_noext_ks", 32'(ks_b), 32'h2000_0000);
    chk("t4_noext_evt", 32'(bus_b.evt_valid), 32'h1);
    send(8'h29);
    chk("t4_space_ks", 32'(ks_a), 32'h2000_0000);
    chk("t4_space_key", 32'(bus_a.evt_key), 32'd29);
    chk("t4_space_press", 32'(bus_a.evt_press), 32'h1);
    pop();
    chk("t4_empty", 32'(bus_a.evt_valid), 32'h0);
    chk("t4_noext_empty", 32'(bus_b.evt_valid), 32'h0);

    // 5: reset after a break prefix.
    send(8'hF0);
    resetn = 1'b0;
    #2;
    chk("t5_rst_ks", 32'(ks_a), 32'h0);
    chk("t5_rst_evt_valid", 32'(bus_a.evt_valid), 32'h0);
    chk("t5_rst_ovf", 32'(ovf_a), 32'h0);
    chk("t5_rst_rel", 32'(rel_a), 32'h0);
    chk("t5_rst_ks_noext", 32'(ks_b), 32'h0);
    tick();
    resetn = 1'b1;
    send(8'h16);
    chk("t5_key1_ks", 32'(ks_a), 32'h1);
    chk("t5_key1_no_rel", 32'(rel_a), 32'h0);
    chk("t5_key1_press", 32'(bus_a.evt_press), 32'h1);
    send(8'hAA); send(8'hFA);
    chk("t5_ctrl_ks", 32'(ks_a), 32'h1);

    // 6: clear_state coinciding with a break prefix.
    send(8'h1E); send(8'h26);
    chk("t6_held_ks", 32'(ks_a), 32'h7);
    clear_state = 1'b1;
    send(8'hF0);
    clear_state = 1'b0;
    chk("t6_clear_ks", 32'(ks_a), 32'h0);
    chk("t6_clear_no_rel", 32'(rel_a), 32'h0);
    chk("t6_fifo_head_key", 32'(bus_a.evt_key), 32'd0);
    chk("t6_fifo_head_press", 32'(bus_a.evt_press), 32'h1);
    send(8'h16);
    chk("t6_key1_again", 32'(ks_a), 32'h1);
    pop();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t6_drain_vld%0d", i), 32'(bus_a.evt_valid), 32'h1);
      chk($sformatf("t6_drain_key%0d", i), 32'(bus_a.evt_key), 32'(drain6[i]));
      chk($sformatf("t6_drain_press%0d", i), 32'(bus_a.evt_press), 32'h1);
      pop();
    end
    chk("t6_drained", 32'(bus_a.evt_valid), 32'h0);
    chk("t6_ovf", 32'(ovf_a), 32'h0);
    chk("t6_noext_ks", 32'(ks_b), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
